traffic_intersection_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/traffic_intersection_ctrl_if.sv | 14 +
 rtl/flash_blinker.sv | 26 ++
 rtl/traffic_intersection_ctrl.sv | 117 +++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp patterns and phase-duration helpers for the
// two-direction intersection controller.
package traffic_pkg;

  typedef enum logic [3:0] {
    NS_LEFT   = 4'd0,
    NS_GREEN  = 4'd1,
    NS_YELLOW = 4'd2,
    NS_CLEAR  = 4'd3,
    EW_LEFT   = 4'd4,
    EW_GREEN  = 4'd5,
    EW_YELLOW = 4'd6,
    EW_CLEAR  = 4'd7,
    PREEMPT   = 4'd8,
    FLASH     = 4'd9
  } state_t;

  // Head encoding is {left, green, yellow, red}
  localparam logic [3:0] LT_LEFT   = 4'b1001;
  localparam logic [3:0] LT_GREEN  = 4'b0100;
  localparam logic [3:0] LT_YELLOW = 4'b0010;
  localparam logic [3:0] LT_RED    = 4'b0001;
  localparam logic [3:0] LT_OFF    = 4'b0000;

  function automatic int unsigned phase_reload(input state_t s,
                                               input int unsigned left_cyc,
                                               input int unsigned green_cyc,
                                               input int unsigned yellow_cyc,
                                               input int unsigned clear_cyc);
    case (s)
      NS_LEFT,   EW_LEFT:   return left_cyc - 1;
      NS_GREEN,  EW_GREEN:  return green_cyc - 1;
      NS_YELLOW, EW_YELLOW: return yellow_cyc - 1;
      NS_CLEAR,  EW_CLEAR:  return clear_cyc - 1;
      default:              return 0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      NS_LEFT:   return NS_GREEN;
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return NS_CLEAR;
      NS_CLEAR:  return EW_LEFT;
      EW_LEFT:   return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return EW_CLEAR;
      default:   return NS_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Request inputs and signal-head outputs of the intersection controller.
interface traffic_intersection_ctrl_if;
  logic       emergency;
  logic       flash;
  logic [3:0] ns_out;
  logic [3:0] ew_out;
  logic [3:0] phase;
  logic       preempt_active;

  modport master (output emergency, flash,
                  input  ns_out, ew_out, phase, preempt_active);
  modport slave  (input  emergency, flash,
                  output ns_out, ew_out, phase, preempt_active);
endinterface

// File: rtl/flash_blinker.sv
// Half-period divider for the fault flash; held at blink=1 while disabled so
// every flash episode starts with the lamps lit.
module flash_blinker #(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic blink
);
  localparam int unsigned W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (cnt == W'(FLASH_HALF - 1)) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-direction intersection phase sequencer with emergency preemption and
// flashing-fault mode; all lamp outputs decode from registered state.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned LEFT_CYC    = 5,
  parameter int unsigned GREEN_CYC   = 10,
  parameter int unsigned YELLOW_CYC  = 3,
  parameter int unsigned CLEAR_CYC   = 1,
  parameter int unsigned PREEMPT_MIN = 2,
  parameter int unsigned FLASH_HALF  = 4,
  parameter int unsigned CNT_W       = 5
) (
  input logic                        clk,
  input logic                        reset,
  traffic_intersection_ctrl_if.slave bus
);

  state_t           state_q, state_d, sv_state_q, sv_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, sv_cnt_q, sv_cnt_d, pre_q, pre_d;
  logic [3:0]       ns_d, ew_d;
  logic             blink;

  function automatic logic [CNT_W-1:0] reload(input state_t s);
    return CNT_W'(phase_reload(s, LEFT_CYC, GREEN_CYC, YELLOW_CYC, CLEAR_CYC));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NS_LEFT;
      cnt_q      <= reload(NS_LEFT);
      sv_state_q <= NS_LEFT;
      sv_cnt_q   <= reload(NS_LEFT);
      pre_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sv_state_q <= sv_state_d;
      sv_cnt_q   <= sv_cnt_d;
      pre_q      <= pre_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sv_state_d = sv_state_q;
    sv_cnt_d   = sv_cnt_q;
    pre_d      = pre_q;
    if (bus.flash) begin
      state_d    = FLASH;
      sv_state_d = NS_LEFT;
      sv_cnt_d   = reload(NS_LEFT);
    end else begin
      case (state_q)
        FLASH: begin
          state_d = EW_CLEAR;
          cnt_d   = reload(EW_CLEAR);
        end
        PREEMPT: begin
          // Minimum-hold counter keeps running while emergency stays high,
          // so a held or re-pulsed request only stretches the exit.
          if (!bus.emergency && pre_q == '0) begin
            state_d = sv_state_q;
            cnt_d   = sv_cnt_q;
          end else if (pre_q != '0) begin
            pre_d = pre_q - CNT_W'(1);
          end
        end
        default: begin
          if (bus.emergency) begin
            state_d    = PREEMPT;
            sv_state_d = state_q;
            sv_cnt_d   = cnt_q;
            pre_d      = CNT_W'(PREEMPT_MIN - 1);
          end else if (cnt_q == '0) begin
            state_d = next_phase(state_q);
            cnt_d   = reload(next_phase(state_q));
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  flash_blinker #(.FLASH_HALF(FLASH_HALF)) u_blinker (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == FLASH),
    .blink  (blink)
  );

  always_comb begin
    ns_d = LT_RED;
    ew_d = LT_RED;
    case (state_q)
      NS_LEFT:   ns_d = LT_LEFT;
      NS_GREEN:  ns_d = LT_GREEN;
      NS_YELLOW: ns_d = LT_YELLOW;
      EW_LEFT:   ew_d = LT_LEFT;
      EW_GREEN:  ew_d = LT_GREEN;
      EW_YELLOW: ew_d = LT_YELLOW;
      FLASH: begin
        ns_d = blink ? LT_YELLOW : LT_OFF;
        ew_d = blink ? LT_RED    : LT_OFF;
      end
      default: ;
    endcase
  end

  assign bus.ns_out         = ns_d;
  assign bus.ew_out         = ew_d;
  assign bus.phase          = state_q;
  assign bus.preempt_active = (state_q == PREEMPT);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Randomized and directed checking of the intersection controller against a
// cycle-level behavioural model of phases, preemption and flash.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int unsigned LEFT_CYC    = 5;
  localparam int unsigned GREEN_CYC   = 10;
  localparam int unsigned YELLOW_CYC  = 3;
  localparam int unsigned CLEAR_CYC   = 1;
  localparam int unsigned PREEMPT_MIN = 2;
  localparam int unsigned FLASH_HALF  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  traffic_intersection_ctrl_if bus ();

  traffic_intersection_ctrl #(
    .LEFT_CYC    (LEFT_CYC),
    .GREEN_CYC   (GREEN_CYC),
    .YELLOW_CYC  (YELLOW_CYC),
    .CLEAR_CYC   (CLEAR_CYC),
    .PREEMPT_MIN (PREEMPT_MIN),
    .FLASH_HALF  (FLASH_HALF),
    .CNT_W       (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: mode 0 = cycling, 1 = preempt hold, 2 = flash.  m_rem counts
  // cycles still to be shown in the current phase, including this one.
  int dur[8];
  int m_mode, m_ph, m_rem, m_sv_ph, m_sv_rem, m_pre_age, m_flash_age;
  bit armed = 1'b0;

  int ns_hist[16];
  int ew_hist[16];
  int pre_seen;
  logic [3:0] last_ns, last_phase;
  logic       last_pre;

  function automatic state_t ph_state(input int p);
    case (p)
      0: return NS_LEFT;   1: return NS_GREEN;
      2: return NS_YELLOW; 3: return NS_CLEAR;
      4: return EW_LEFT;   5: return EW_GREEN;
      6: return EW_YELLOW; default: return EW_CLEAR;
    endcase
  endfunction

  function automatic logic [3:0] lamp(input int sub);
    case (sub)
      0: return LT_LEFT;
      1: return LT_GREEN;
      2: return LT_YELLOW;
      default: return LT_RED;
    endcase
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) begin
      ns_hist[i] = 0;
      ew_hist[i] = 0;
    end
    pre_seen = 0;
  endtask

  // Check the state shown this cycle, then apply inputs for the next edge.
  task automatic step(input bit r, input bit f, input bit e);
    logic [3:0] ens, eew;
    state_t     eph;
    bit         blink;
    @(negedge clk);
    if (armed) begin
      if (m_mode == 1) begin
        ens = LT_RED; eew = LT_RED; eph = PREEMPT;
      end else if (m_mode == 2) begin
        blink = ((m_flash_age / FLASH_HALF) % 2) == 0;
        ens = blink ? 4'b0010 : 4'b0000;
        eew = blink ? 4'b0001 : 4'b0000;
        eph = FLASH;
      end else begin
        ens = (m_ph < 4) ? lamp(m_ph % 4) : LT_RED;
        eew = (m_ph < 4) ? LT_RED : lamp(m_ph % 4);
        eph = ph_state(m_ph);
      end
      check_eq("ns_out", 32'(bus.ns_out), 32'(ens));
      check_eq("ew_out", 32'(bus.ew_out), 32'(eew));
      check_eq("phase", 32'(bus.phase), 32'(eph));
      check_eq("preempt_active", 32'(bus.preempt_active), 32'(m_mode == 1));
      check_eq("safety", 32'((|bus.ns_out[3:1]) && (|bus.ew_out[3:1])), 32'd0);
      ns_hist[bus.ns_out]++;
      ew_hist[bus.ew_out]++;
      if (bus.preempt_active) pre_seen++;
      last_ns    = bus.ns_out;
      last_pre   = bus.preempt_active;
      last_phase = bus.phase;
    end
    reset         = r;
    bus.flash     = f;
    bus.emergency = e;
    if (r) begin
      m_mode = 0; m_ph = 0; m_rem = dur[0];
      armed = 1'b1;
    end else if (f) begin
      m_flash_age = (m_mode == 2) ? m_flash_age + 1 : 0;
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0; m_ph = 7; m_rem = dur[7];
    end else if (m_mode == 1) begin
      m_pre_age++;
      if (!e && m_pre_age >= int'(PREEMPT_MIN)) begin
        m_mode = 0; m_ph = m_sv_ph; m_rem = m_sv_rem;
      end
    end else if (e) begin
      m_mode = 1; m_sv_ph = m_ph; m_sv_rem = m_rem; m_pre_age = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_ph  = (m_ph + 1) % 8;
        m_rem = dur[m_ph];
      end
    end
  endtask

  initial begin
    bit fl;
    dur[0] = LEFT_CYC; dur[1] = GREEN_CYC; dur[2] = YELLOW_CYC; dur[3] = CLEAR_CYC;
    dur[4] = LEFT_CYC; dur[5] = GREEN_CYC; dur[6] = YELLOW_CYC; dur[7] = CLEAR_CYC;
    bus.flash = 1'b0;
    bus.emergency = 1'b0;
    clear_hist();

    // Two full undisturbed periods
    step(1, 0, 0);
    repeat (76) step(0, 0, 0);
    check_eq("idle_ns_left", ns_hist[4'b1001], 10);
    check_eq("idle_ns_green", ns_hist[4'b0100], 20);
    check_eq("idle_ns_yellow", ns_hist[4'b0010], 6);
    check_eq("idle_ew_green", ew_hist[4'b0100], 20);
    check_eq("idle_ew_left", ew_hist[4'b1001], 10);

    // One-cycle emergency at NS_GREEN count 6
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    step(0, 0, 1);
    clear_hist();
    repeat (12) step(0, 0, 0);
    check_eq("pulse_preempt_len", pre_seen, 2);
    check_eq("pulse_green_rest", ns_hist[4'b0100], 7);

    // Emergency held 9 cycles during EW_YELLOW count 1
    step(1, 0, 0);
    repeat (35) step(0, 0, 0);
    clear_hist();
    repeat (9) step(0, 0, 1);
    repeat (12) step(0, 0, 0);
    check_eq("hold_preempt_len", pre_seen, 9);
    check_eq("hold_ew_yellow", ew_hist[4'b0010], 3);

    // Re-pulse inside PREEMPT stretches the hold, resumes the original phase
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    step(0, 0, 1);
    clear_hist();
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (10) step(0, 0, 0);
    check_eq("repulse_preempt_len", pre_seen, 3);
    check_eq("repulse_green_rest", ns_hist[4'b0100], 7);

    // Flash asserted during PREEMPT for 20 cycles
    step(1, 0, 0);
    step(0, 0, 1);
    clear_hist();
    repeat (20) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    check_eq("flash_on", ns_hist[4'b0010], 12);
    check_eq("flash_off", ns_hist[4'b0000], 8);
    check_eq("flash_exit_nsleft", 32'(last_phase), 32'(NS_LEFT));

    // Reset mid-EW_GREEN with emergency and flash both high
    step(1, 0, 0);
    repeat (26) step(0, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    check_eq("rst_ns", 32'(last_ns), 32'b1001);
    check_eq("rst_pre", 32'(last_pre), 32'd0);

    // Randomized soak
    fl = 1'b0;
    step(1, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom % 150 == 0) fl = ~fl;
      step(($urandom % 1500) == 0, fl, ($urandom % 6) == 0);
    end
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
